// File: rtl/snake_dir_queue.sv
// snake_dir_queue: per-player press detection, turn legality filter and
// turn FIFO; one buffered turn is committed to dir on each tick.
// Optional input debounce filter is enabled by defining DIR_DEBOUNCE_EN.
module snake_dir_queue #(
  parameter int NUM_PLAYERS     = 2,
  parameter int QUEUE_DEPTH     = 2,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [4*NUM_PLAYERS-1:0] btns,
  input  logic                     tick,
  output logic [2*NUM_PLAYERS-1:0] dir,
  output logic [NUM_PLAYERS-1:0]   q_empty,
  output logic [NUM_PLAYERS-1:0]   overflow
);

  localparam int PTR_W = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam int CNT_W = $clog2(QUEUE_DEPTH + 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(QUEUE_DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(QUEUE_DEPTH);

  for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_player
    logic [3:0] raw;
    logic [3:0] nib;

    assign raw = btns[4*p +: 4];

`ifdef DIR_DEBOUNCE_EN
    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DB_W-1:0] DB_MAX = DB_W'(DEBOUNCE_CYCLES);

    logic [3:0]      db_last;
    logic [3:0]      db_filt;
    logic [DB_W-1:0] db_cnt;
    logic [DB_W-1:0] db_cnt_next;

    // Count consecutive edges on which the raw nibble has been stable
    always_comb begin
      db_cnt_next = db_cnt;
      if (raw != db_last)
        db_cnt_next = DB_W'(1);
      else if (db_cnt != DB_MAX)
        db_cnt_next = db_cnt + DB_W'(1);
    end

    // Filtered nibble follows raw once it has been stable long enough
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        db_last <= '0;
        db_filt <= '0;
        db_cnt  <= '0;
      end else begin
        db_last <= raw;
        db_cnt  <= db_cnt_next;
        if (db_cnt_next == DB_MAX)
          db_filt <= raw;
      end
    end

    assign nib = db_filt;
`else
    assign nib = raw;
`endif

    logic [3:0]       prev;
    logic [1:0]       mem [QUEUE_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] tail_ptr;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_next;
    logic [1:0]       cand;
    logic [1:0]       ref_dir;
    logic [1:0]       dir_r;
    logic             onehot;
    logic             valid;
    logic             full;
    logic             pop;
    logic             push;
    logic             empty_r;
    logic             ovf_r;

    // Press detection, legality check against the newest queued turn, and
    // push/pop decisions for this edge
    always_comb begin
      onehot = (nib != '0) && ((nib & (nib - 4'd1)) == '0);
      unique case (nib)
        4'b0010: cand = 2'b01;
        4'b0100: cand = 2'b10;
        4'b1000: cand = 2'b11;
        default: cand = 2'b00;
      endcase
      tail_ptr = (wr_ptr == '0) ? PTR_LAST : wr_ptr - PTR_W'(1);
      ref_dir  = (count != '0) ? mem[tail_ptr] : dir_r;
      valid    = onehot && (nib != prev) && (cand != ref_dir)
                 && (cand != (ref_dir ^ 2'b01));
      full     = (count == CNT_FULL);
      pop      = tick && (count != '0);
      push     = valid && (!full || pop);
      count_next = count;
      if (push && !pop)
        count_next = count + CNT_W'(1);
      else if (pop && !push)
        count_next = count - CNT_W'(1);
    end

    // Pointer, occupancy, committed direction and status flags
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        prev    <= '0;
        wr_ptr  <= '0;
        rd_ptr  <= '0;
        count   <= '0;
        dir_r   <= 2'b10;
        empty_r <= 1'b1;
        ovf_r   <= 1'b0;
      end else begin
        prev    <= nib;
        count   <= count_next;
        empty_r <= (count_next == '0);
        ovf_r   <= valid && full && !pop;
        if (push)
          wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + PTR_W'(1);
        if (pop) begin
          rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + PTR_W'(1);
          dir_r  <= mem[rd_ptr];
        end
      end
    end

    // FIFO storage; on a full push+pop the head is read before being reused
    always_ff @(posedge clk) begin
      if (push)
        mem[wr_ptr] <= cand;
    end

    assign dir[2*p +: 2] = dir_r;
    assign q_empty[p]    = empty_r;
    assign overflow[p]   = ovf_r;
  end

endmodule
